// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } arb_state_t;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data has priority; a grant streak counter forces a fetch grant to prevent starvation.
//
// state  | meaning
// IDLE   | no access in flight, pick a winner from pending requests
// BUSY_I | fetch access presented on the memory port, waiting for MemReady
// BUSY_D | data access presented on the memory port, waiting for MemReady
// DONE_I | IValid pulse; fetch request still held, so requests are ignored
// DONE_D | DValid pulse; data request still held, so requests are ignored
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = MEM_ADDR_W,
    parameter int DATA_WIDTH   = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IReq,
    input  logic [ADDR_WIDTH-1:0] IAddr,
    output logic [DATA_WIDTH-1:0] IRdata,
    output logic                  IValid,
    input  logic                  DReq,
    input  logic                  DWe,
    input  logic [ADDR_WIDTH-1:0] DAddr,
    input  logic [DATA_WIDTH-1:0] DWdata,
    output logic [DATA_WIDTH-1:0] DRdata,
    output logic                  DValid,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWdata,
    input  logic [DATA_WIDTH-1:0] MemRdata,
    input  logic                  MemReady,
    output logic                  StallF,
    output logic                  StallM
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t          state, nextState;
    logic [STREAK_W-1:0] streak, nextStreak;
    logic                grantI, grantD;

    always_comb begin
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                if (DReq && !(IReq && streak == STREAK_MAX)) begin
                    grantD    = 1'b1;
                    nextState = BUSY_D;
                end else if (IReq) begin
                    grantI    = 1'b1;
                    nextState = BUSY_I;
                end
            end
            BUSY_I:  if (MemReady) nextState = DONE_I;
            BUSY_D:  if (MemReady) nextState = DONE_D;
            DONE_I:  nextState = IDLE;
            DONE_D:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Streak counts only data grants that bypassed a waiting fetch.
    always_comb begin
        nextStreak = streak;
        if (grantI) begin
            nextStreak = '0;
        end else if (grantD) begin
            if (!IReq)
                nextStreak = '0;
            else if (streak != STREAK_MAX)
                nextStreak = streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= nextState;
            streak <= nextStreak;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
        end else begin
            MemReq <= (nextState == BUSY_I) || (nextState == BUSY_D);
            if (grantD) begin
                MemWe    <= DWe;
                MemAddr  <= DAddr;
                MemWdata <= DWdata;
            end else if (grantI) begin
                MemWe   <= 1'b0;
                MemAddr <= IAddr;
            end else if (nextState != BUSY_D) begin
                MemWe <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            IValid <= 1'b0;
            DValid <= 1'b0;
            IRdata <= '0;
            DRdata <= '0;
        end else begin
            IValid <= (nextState == DONE_I);
            DValid <= (nextState == DONE_D);
            if (state == BUSY_I && MemReady)
                IRdata <= MemRdata;
            if (state == BUSY_D && MemReady && !MemWe)
                DRdata <= MemRdata;
        end
    end

    assign StallF = IReq & ~IValid;
    assign StallM = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; each task walks one scenario cycle by cycle.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IReq, DReq, DWe, MemReady;
    logic [31:0] IAddr, DAddr, DWdata, MemRdata;
    logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
    logic        IValid, DValid, MemReq, MemWe, StallF, StallM;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata), .DValid(DValid),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemReady(MemReady),
        .StallF(StallF), .StallM(StallM)
    );

    always #5 CLK = ~CLK;

    task automatic nextCycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0; IReq = 0; DReq = 0; DWe = 0; MemReady = 0;
        IAddr = 0; DAddr = 0; DWdata = 0; MemRdata = 0;
        #12;
        checks++;
        if ({MemReq, MemWe, IValid, DValid, StallF, StallM} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {MemReq, MemWe, IValid, DValid, StallF, StallM});
        end
        checks++;
        if (MemAddr !== 0 || MemWdata !== 0 || IRdata !== 0 || DRdata !== 0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero", MemAddr, MemWdata, IRdata, DRdata);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_lone_fetch;
        nextCycle();
        IReq = 1; IAddr = 32'h0000_0040; #1;
        checks++;
        if (StallF !== 1'b1 || MemReq !== 1'b0) begin
            errors++; $display("FAIL fetch_c0: got StallF=%b MemReq=%b expected 1 0", StallF, MemReq);
        end
        nextCycle(); #1;
        checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h40 || MemWe !== 1'b0 || StallF !== 1'b1) begin
            errors++;
            $display("FAIL fetch_c1: got req=%b addr=%h we=%b stall=%b expected 1 00000040 0 1", MemReq, MemAddr, MemWe, StallF);
        end
        MemReady = 1; MemRdata = 32'h2008_0005;
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (IValid !== 1'b1 || IRdata !== 32'h2008_0005 || StallF !== 1'b0 || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c2: got valid=%b data=%h stall=%b req=%b expected 1 20080005 0 0", IValid, IRdata, StallF, MemReq);
        end
        IReq = 0;
        nextCycle(); #1;
        checks++;
        if (IValid !== 1'b0 || MemReq !== 1'b0) begin
            errors++; $display("FAIL fetch_c3: got valid=%b req=%b expected 0 0", IValid, MemReq);
        end
    endtask

    task automatic test_simultaneous;
        nextCycle();
        IReq = 1; IAddr = 32'h44; DReq = 1; DWe = 0; DAddr = 32'h100;
        nextCycle(); #1;
        checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h100 || MemWe !== 1'b0) begin
            errors++; $display("FAIL simul_dgrant: got req=%b addr=%h we=%b expected 1 00000100 0", MemReq, MemAddr, MemWe);
        end
        MemReady = 1; MemRdata = 32'h1111_2222;
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (DValid !== 1'b1 || DRdata !== 32'h1111_2222 || StallM !== 1'b0 || StallF !== 1'b1) begin
            errors++;
            $display("FAIL simul_dvalid: got v=%b d=%h sm=%b sf=%b expected 1 11112222 0 1", DValid, DRdata, StallM, StallF);
        end
        DReq = 0;
        nextCycle(); #1;
        checks++;
        if (MemReq !== 1'b0 || StallF !== 1'b1) begin
            errors++; $display("FAIL simul_gap: got req=%b sf=%b expected 0 1", MemReq, StallF);
        end
        nextCycle(); #1;
        checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h44 || StallF !== 1'b1) begin
            errors++; $display("FAIL simul_igrant: got req=%b addr=%h sf=%b expected 1 00000044 1", MemReq, MemAddr, StallF);
        end
        MemReady = 1; MemRdata = 32'h3333_4444;
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (IValid !== 1'b1 || IRdata !== 32'h3333_4444 || StallF !== 1'b0) begin
            errors++; $display("FAIL simul_ivalid: got v=%b d=%h sf=%b expected 1 33334444 0", IValid, IRdata, StallF);
        end
        IReq = 0;
        nextCycle();
    endtask

    task automatic test_store;
        nextCycle();
        DReq = 1; DWe = 1; DAddr = 32'h200; DWdata = 32'hDEAD_BEEF;
        nextCycle();
        DAddr = 32'h0; DWdata = 32'h0; #1;
        checks++;
        if (MemReq !== 1'b1 || MemWe !== 1'b1 || MemAddr !== 32'h200 || MemWdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_busy: got req=%b we=%b addr=%h wd=%h expected 1 1 00000200 deadbeef", MemReq, MemWe, MemAddr, MemWdata);
        end
        MemReady = 1; MemRdata = 32'hFFFF_FFFF;
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (DValid !== 1'b1 || DRdata !== 32'h1111_2222 || MemWe !== 1'b0) begin
            errors++; $display("FAIL store_done: got v=%b d=%h we=%b expected 1 11112222 0", DValid, DRdata, MemWe);
        end
        DReq = 0; DWe = 0;
        nextCycle(); #1;
        checks++;
        if (DValid !== 1'b0) begin
            errors++; $display("FAIL store_pulse: got DValid=%b expected 0", DValid);
        end
    endtask

    task automatic test_starvation;
        logic [9:0] expFetch;
        expFetch = 10'b10000_10000;
        nextCycle();
        IReq = 1; IAddr = 32'h80; DReq = 1; DWe = 0; DAddr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            nextCycle(); #1;
            checks++;
            if (MemReq !== 1'b1 || MemAddr !== (expFetch[k] ? 32'h80 : 32'h300)) begin
                errors++;
                $display("FAIL starve_grant%0d: got req=%b addr=%h expected 1 %h", k, MemReq, MemAddr,
                         expFetch[k] ? 32'h80 : 32'h300);
            end
            MemReady = 1; MemRdata = 32'h5000_0000 + k;
            nextCycle();
            MemReady = 0; #1;
            checks++;
            if ({IValid, DValid} !== (expFetch[k] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL starve_valid%0d: got I=%b D=%b expected %b", k, IValid, DValid, expFetch[k] ? 2'b10 : 2'b01);
            end
            if (k == 9) begin
                IReq = 0; DReq = 0;
            end
            nextCycle();
        end
    endtask

    task automatic test_latency;
        nextCycle();
        IReq = 1; IAddr = 32'h500;
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            IAddr = 32'h0; #1;
            checks++;
            if (MemReq !== 1'b1 || MemAddr !== 32'h500 || IValid !== 1'b0) begin
                errors++; $display("FAIL lat_hold%0d: got req=%b addr=%h v=%b expected 1 00000500 0", c, MemReq, MemAddr, IValid);
            end
            if (c == 5) begin
                MemReady = 1; MemRdata = 32'hCAFE_F00D;
            end
        end
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (IValid !== 1'b1 || IRdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL lat_valid: got v=%b d=%h expected 1 cafef00d", IValid, IRdata);
        end
        IReq = 0;
        nextCycle();
        MemReady = 1; MemRdata = 32'h1234_5678; #1;
        checks++;
        if (IValid !== 1'b0) begin
            errors++; $display("FAIL lat_pulse: got IValid=%b expected 0", IValid);
        end
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (IValid !== 1'b0 || DValid !== 1'b0 || MemReq !== 1'b0 || IRdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL stray_ready: got iv=%b dv=%b req=%b d=%h expected 0 0 0 cafef00d", IValid, DValid, MemReq, IRdata);
        end
    endtask

    task automatic test_reset_mid_access;
        nextCycle();
        DReq = 1; DWe = 0; DAddr = 32'h600;
        nextCycle(); #1;
        checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h600) begin
            errors++; $display("FAIL rst_pre: got req=%b addr=%h expected 1 00000600", MemReq, MemAddr);
        end
        RST = 1'b0; #1;
        checks++;
        if (MemReq !== 1'b0 || DValid !== 1'b0 || MemAddr !== 32'h0 || DRdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got req=%b dv=%b addr=%h d=%h expected 0 0 0 0", MemReq, DValid, MemAddr, DRdata);
        end
        MemReady = 1; MemRdata = 32'hAAAA_AAAA;
        @(negedge CLK);
        MemReady = 0;
        RST = 1'b1;
        nextCycle(); #1;
        checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h600 || DValid !== 1'b0) begin
            errors++; $display("FAIL rst_regrant: got req=%b addr=%h dv=%b expected 1 00000600 0", MemReq, MemAddr, DValid);
        end
        MemReady = 1; MemRdata = 32'h0BAD_CAFE;
        nextCycle();
        MemReady = 0; #1;
        checks++;
        if (DValid !== 1'b1 || DRdata !== 32'h0BAD_CAFE || StallM !== 1'b0) begin
            errors++; $display("FAIL rst_complete: got v=%b d=%h sm=%b expected 1 0badcafe 0", DValid, DRdata, StallM);
        end
        DReq = 0;
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_latency();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester and its data-memory (MEM stage) requester. Arbitrates fixed priority to data with a starvation guard for fetch, registers the winning request onto the memory port, returns read data with a one-cycle valid pulse, and generates `StallF`/`StallM` for the hazard logic. Sits between the datapath's `PC`/`Instr` and `ALUOut`/`WriteData`/`MemWriteM`/`ReadData` ports and a single external memory.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `STARVE_LIMIT`, 4, maximum consecutive data grants while fetch is pending; range ≥1

- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-low reset
- `IReq`  in  1  fetch request, held until `IValid`
- `IAddr`  in  ADDR_WIDTH  fetch address (PC)
- `IRdata`  out  DATA_WIDTH  fetched instruction
- `IValid`  out  1  one-cycle completion pulse for fetch
- `DReq`  in  1  data request, held until `DValid`
- `DWe`  in  1  1 = store, 0 = load
- `DAddr`  in  ADDR_WIDTH  data address (ALUOut)
- `DWdata`  in  DATA_WIDTH  store data
- `DRdata`  out  DATA_WIDTH  load data
- `DValid`  out  1  one-cycle completion pulse for data
- `MemReq`  out  1  memory request, held until `MemReady`
- `MemWe`  out  1  memory write enable
- `MemAddr`  out  ADDR_WIDTH  memory address
- `MemWdata`  out  DATA_WIDTH  memory write data
- `MemRdata`  in  DATA_WIDTH  memory read data, valid with `MemReady`
- `MemReady`  in  1  memory completion, one cycle
- `StallF`  out  1  `IReq & ~IValid`, combinational
- `StallM`  out  1  `DReq & ~DValid`, combinational

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`, `DONE_I`, `DONE_D`.
- `IDLE`: if any request is pending, select a winner, latch its addr/we/wdata into port registers, and go to `BUSY_x`. With no request, stay in `IDLE`.
- Winner rule: data wins unless `IReq` is high and `streak == STARVE_LIMIT`, in which case fetch wins.
- `streak`: increments on every data grant made while `IReq` is high, saturates at `STARVE_LIMIT`, and clears on any fetch grant or any data grant made with `IReq` low. Width is `$clog2(STARVE_LIMIT+1)`.
- `BUSY_x`:
  - `MemReq=1`; `MemWe` is the latched `DWe` in `BUSY_D` and 0 in `BUSY_I`.
  - On `MemReady`, go to `DONE_x`. Reads capture `MemRdata` into `IRdata`/`DRdata`.
  - Stores do not update `DRdata`.
- `DONE_x`: `xValid=1` for exactly one cycle, then `IDLE`. Requests are ignored in `DONE_x`, because the requester still holds the completed request that cycle.
- `MemReady` outside `BUSY_x` is ignored.
- Requester inputs may change freely after grant; the port registers hold the values.
- Reset (async, any state):
  - State goes to `IDLE` and `streak` to 0.
  - `MemReq`, `MemWe`, `IValid`, `DValid` go to 0; `MemAddr`, `MemWdata`, `IRdata`, `DRdata` go to 0.
  - An in-flight memory access is abandoned; the memory is required to tolerate `MemReq` dropping.

## Timing
- All outputs except `StallF`/`StallM` are registered.
- Minimum access: request seen in `IDLE` at cycle 0 → `MemReq` high at cycle 1 → with `MemReady` at cycle 1, `xValid` at cycle 2. The earliest next grant is decided at cycle 3.
- Memory latency of L cycles gives `xValid` at cycle 1+L.
- Back-to-back throughput is one access per 3 cycles at L=1.
- Stall timing: `StallF`/`StallM` fall in the `xValid` cycle, so the pipeline advances on that edge.

## Structure
- Shared package `mem_arb_pkg`: state enum `arb_state_t` (5 states above) and default width constants `MEM_ADDR_W`/`MEM_DATA_W` = 32.
- Single flat module; no sub-module. Next-state/winner logic is combinational, and state, `streak`, port registers and response registers are sequential.

## Test plan
- Lone fetch, L=1: `IReq=1`, `IAddr=0x0000_0040`, `MemRdata=0x2008_0005` → `MemReq` at cycle 1 with `MemAddr=0x40`, `MemWe=0`. At cycle 2, `IValid=1` and `IRdata=0x2008_0005`; `StallF` is 1 at cycles 0–1 and 0 at cycle 2.
- Simultaneous requests: `IReq` and `DReq` (load `DAddr=0x100`) both high in `IDLE` → data granted first and `DValid` pulses. The fetch is granted 3 cycles after the data grant, and `StallF` stays high throughout.
- Store: `DWe=1`, `DAddr=0x200`, `DWdata=0xDEAD_BEEF` → `MemWe=1`, `MemWdata=0xDEADBEEF` during `BUSY_D`; `DValid` pulses and `DRdata` is unchanged.
- Starvation, `STARVE_LIMIT=4`, `IReq` and `DReq` held high continuously → grant order D,D,D,D,I,D,…; `streak` returns to 0 after the I grant.
- Variable latency: `MemReady` delayed 5 cycles → `MemReq`/`MemAddr` stable for 5 cycles and `IValid` exactly one cycle later. A stray `MemReady` in `IDLE` is ignored.
- Reset mid-access: `RST` low during `BUSY_D` → `MemReq=0`, state `IDLE` immediately, no `DValid`. After release, the still-held `DReq` is re-granted and completes.
